// File: rtl/serial_frame_pkg.sv
// Shared types and helpers for the serial frame deserializer.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        DELIVER
    } rx_state_t;

    localparam logic START_BIT  = 1'b1;
    localparam logic IDLE_LEVEL = 1'b0;

    // XOR-reduction of a word; callers zero-extend narrower data (words up to 32 bits).
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_frame_deserializer_out_skid_buffer.sv
// One-deep valid/ready output register holding the received word and its parity flag.
module out_skid_buffer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             din_err,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             parity_err,
    output logic             overrun
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             space;

    // Load when empty or when the held word leaves this cycle; otherwise drop and flag.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        err_d   = err_q;
        space   = !valid_q || dout_ready;
        overrun = 1'b0;
        if (load) begin
            if (space) begin
                dout_d  = din;
                err_d   = din_err;
                valid_d = 1'b1;
            end else begin
                overrun = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            dout_q  <= dout_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign parity_err = err_q;

endmodule

// File: rtl/serial_frame_deserializer.sv
// Framed serial receiver: start bit, WIDTH data bits, optional even-parity bit.
module serial_frame_deserializer
    import serial_frame_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned PARITY_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             sin,
    input  logic             msb_first,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             parity_err,
    output logic             overrun,
    output logic             busy
);

    localparam int unsigned   CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MAX_IDX  = CW'(WIDTH);

    rx_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             msb_q, msb_d;
    logic             perr_q, perr_d;
    logic             load;

    // Next-state, accumulator and parity capture; only DELIVER ignores bit_valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        msb_d   = msb_q;
        perr_d  = perr_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bit_valid && sin == START_BIT) begin
                    msb_d   = msb_first;
                    cnt_d   = '0;
                    acc_d   = '0;
                    perr_d  = 1'b0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    if (cnt_q >= MAX_IDX) begin
                        state_d = IDLE;
                    end else begin
                        if (msb_q) acc_d = {acc_q[WIDTH-2:0], sin};
                        else       acc_d = {sin, acc_q[WIDTH-1:1]};
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == LAST_IDX) state_d = (PARITY_EN != 0) ? PARITY : DELIVER;
                    end
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    perr_d  = even_parity(32'(acc_q)) ^ sin;
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                load    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Receiver state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            msb_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            msb_q   <= msb_d;
            perr_q  <= perr_d;
        end
    end

    assign busy = (state_q != IDLE);

    out_skid_buffer #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .din       (acc_q),
        .din_err   ((PARITY_EN != 0) ? perr_q : 1'b0),
        .dout_ready(dout_ready),
        .dout      (dout),
        .dout_valid(dout_valid),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed bench for serial_frame_deserializer (WIDTH=4, PARITY_EN=1).
module tb_serial_frame_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_valid;
    logic       sin;
    logic       msb_first;
    logic [3:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    serial_frame_deserializer #(
        .WIDTH    (4),
        .PARITY_EN(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_valid (bit_valid),
        .sin       (sin),
        .msb_first (msb_first),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .parity_err(parity_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // f[5] is the start bit, f[4:1] data in arrival order, f[0] parity.
    // Returns with the DUT sitting in DELIVER.
    task automatic send_frame(input logic msb, input logic [5:0] f, input int gap);
        for (int i = 5; i >= 0; i--) begin
            bit_valid = 1'b1;
            sin       = f[i];
            msb_first = msb;
            tick();
            bit_valid = 1'b0;
            sin       = 1'b0;
            msb_first = ~msb;
            check("busy_in_frame", 32'(busy), 32'd1);
            if (i != 0) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_in_gap", 32'(busy), 32'd1);
                end
            end
        end
    endtask

    // Finish a frame with ready=1 and check the delivered word.
    task automatic expect_word(input string tag, input logic [3:0] w, input logic e);
        check({tag, "_pre_valid"}, 32'(dout_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(dout_valid), 32'd1);
        check({tag, "_dout"}, 32'(dout), 32'(w));
        check({tag, "_perr"}, 32'(parity_err), 32'(e));
        check({tag, "_idle"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_drained"}, 32'(dout_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        bit_valid  = 1'b0;
        sin        = 1'b0;
        msb_first  = 1'b0;
        dout_ready = 1'b1;
        tick();
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();

        // MSB-first, data 1010, parity 1 then 0.
        send_frame(1'b1, 6'b110101, 0);
        expect_word("t1a", 4'b1010, 1'b1);
        send_frame(1'b1, 6'b110100, 0);
        expect_word("t1b", 4'b1010, 1'b0);

        // LSB-first, data arrives 1,0,0,0.
        send_frame(1'b0, 6'b110000, 0);
        expect_word("t2a", 4'b0001, 1'b1);
        send_frame(1'b0, 6'b110001, 0);
        expect_word("t2b", 4'b0001, 1'b0);

        // Full buffer: second frame is dropped with a one-cycle overrun.
        dout_ready = 1'b0;
        send_frame(1'b1, 6'b110100, 0);
        tick();
        check("t3_first_valid", 32'(dout_valid), 32'd1);
        check("t3_first_dout", 32'(dout), 32'hA);
        send_frame(1'b1, 6'b101010, 0);
        check("t3_overrun_pulse", 32'(overrun), 32'd1);
        tick();
        check("t3_overrun_end", 32'(overrun), 32'd0);
        check("t3_held_dout", 32'(dout), 32'hA);
        check("t3_held_valid", 32'(dout_valid), 32'd1);
        dout_ready = 1'b1;
        tick();
        check("t3_accepted", 32'(dout_valid), 32'd0);

        // Accept and load in the same DELIVER cycle.
        dout_ready = 1'b0;
        send_frame(1'b1, 6'b110100, 0);
        tick();
        check("t4_hold_dout", 32'(dout), 32'hA);
        send_frame(1'b1, 6'b100110, 0);
        dout_ready = 1'b1;
        #1;
        check("t4_no_overrun", 32'(overrun), 32'd0);
        tick();
        check("t4_valid_kept", 32'(dout_valid), 32'd1);
        check("t4_new_dout", 32'(dout), 32'h3);
        check("t4_new_perr", 32'(parity_err), 32'd0);
        tick();
        check("t4_drained", 32'(dout_valid), 32'd0);

        // Gaps between frame bits give the same result.
        send_frame(1'b1, 6'b110101, 1);
        expect_word("t5_gap1", 4'b1010, 1'b1);
        send_frame(1'b1, 6'b110100, 7);
        expect_word("t5_gap7", 4'b1010, 1'b0);

        // Reset mid-frame with a held word.
        dout_ready = 1'b0;
        send_frame(1'b1, 6'b110100, 0);
        tick();
        check("t6_held", 32'(dout_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1;
            msb_first = 1'b1;
            sin       = (i < 2) ? 1'b1 : 1'b0;
            tick();
        end
        bit_valid = 1'b0;
        check("t6_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(dout_valid), 32'd0);
        check("t6_rst_dout", 32'(dout), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_perr", 32'(parity_err), 32'd0);
        tick();
        reset      = 1'b0;
        dout_ready = 1'b1;
        tick();
        send_frame(1'b1, 6'b101101, 0);
        expect_word("t6_fresh", 4'b0110, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
